// File: rtl/control_cubo_verde.sv
// Falling green cube controller: frame-rate fall/land/respawn FSM plus registered pixel-hit flag.
// Define CUBO_LFSR_EN to pick the respawn column from a 10-bit LFSR instead of X_INIT.
module control_cubo_verde #(
    parameter int CUBE_SIZE   = 32,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int FALL_STEP   = 2,
    parameter int HOLD_FRAMES = 30,
    parameter int X_INIT      = 304
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       video_on,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       frame_tick,
    input  logic       pausa,
    output logic       cubo_verde,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [7:0] caidas,
    output logic [1:0] estado
);

    typedef enum logic [1:0] {
        ESPERA     = 2'd0,
        CAYENDO    = 2'd1,
        ATERRIZADO = 2'd2,
        REAPARECE  = 2'd3
    } estado_t;

    localparam int                HOLD_W    = $clog2(HOLD_FRAMES + 1);
    localparam logic [10:0]       FLOOR     = 11'(V_RES - CUBE_SIZE);
    localparam logic [10:0]       STEP      = 11'(FALL_STEP);
    localparam logic [10:0]       SIZE      = 11'(CUBE_SIZE);
    localparam logic [9:0]        X_MAX     = 10'(H_RES - CUBE_SIZE);
    localparam logic [9:0]        X_START   = 10'(X_INIT);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    estado_t           state, state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [10:0]       y_sum;
    logic [9:0]        respawn_x;
    logic              step_ok, do_fall, do_land, do_hold, do_respawn;
    logic              x_hit, y_hit;

    // 11-bit sum so a step near the bottom of the 10-bit range cannot wrap
    assign y_sum   = {1'b0, pos_y} + STEP;
    assign step_ok = frame_tick & ~pausa;
    assign estado  = state;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ESPERA;
        else       state <= state_next;
    end

    // NOTE: default assignment first so no path through the case leaves the signal unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ESPERA:     if (frame_tick)                             state_next = CAYENDO;
            CAYENDO:    if (step_ok && y_sum >= FLOOR)              state_next = ATERRIZADO;
            ATERRIZADO: if (step_ok && hold_cnt == HOLD_LAST)       state_next = REAPARECE;
            REAPARECE:                                              state_next = CAYENDO;
            default:                                                state_next = ESPERA;
        endcase
    end

    always_comb begin
        do_fall    = (state == CAYENDO) && step_ok;
        do_land    = do_fall && (y_sum >= FLOOR);
        do_hold    = (state == ATERRIZADO) && step_ok;
        do_respawn = (state == REAPARECE);
    end

`ifdef CUBO_LFSR_EN
    logic [9:0] lfsr, x_cand;

    // x^10 + x^7 + 1 Fibonacci LFSR; free-running in every state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lfsr <= 10'h2A5;
        else       lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
    end

    assign x_cand    = lfsr & ~10'(CUBE_SIZE - 1);
    assign respawn_x = (x_cand > X_MAX) ? x_cand - 10'd512 : x_cand;
`else
    // Clamp only matters for a misconfigured X_INIT; at sane settings this is X_INIT
    assign respawn_x = (X_START > X_MAX) ? X_MAX : X_START;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_x    <= X_START;
            pos_y    <= '0;
            caidas   <= '0;
            hold_cnt <= '0;
        end else begin
            if (do_respawn) begin
                pos_x  <= respawn_x;
                pos_y  <= '0;
                caidas <= caidas + 8'd1;
            end else if (do_land) begin
                pos_y    <= FLOOR[9:0];
                hold_cnt <= '0;
            end else if (do_fall) begin
                pos_y <= y_sum[9:0];
            end
            if (do_hold) hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign x_hit = ({1'b0, pixel_x} >= {1'b0, pos_x}) && ({1'b0, pixel_x} < {1'b0, pos_x} + SIZE);
    assign y_hit = ({1'b0, pixel_y} >= {1'b0, pos_y}) && ({1'b0, pixel_y} < {1'b0, pos_y} + SIZE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cubo_verde <= 1'b0;
        else       cubo_verde <= video_on & x_hit & y_hit;
    end

endmodule

// File: tb/tb_control_cubo_verde.sv
// Directed self-checking bench for control_cubo_verde (default or CUBO_LFSR_EN build).
module tb_control_cubo_verde;

    logic       clk = 1'b0;
    logic       reset;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       frame_tick;
    logic       pausa;
    logic       cubo_verde;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [7:0] caidas;
    logic [1:0] estado;

    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_x;

    control_cubo_verde dut (
        .clk        (clk),
        .reset      (reset),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .frame_tick (frame_tick),
        .pausa      (pausa),
        .cubo_verde (cubo_verde),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .caidas     (caidas),
        .estado     (estado)
    );

    always #5 clk = ~clk;

`ifdef CUBO_LFSR_EN
    logic [9:0] m_lfsr;
    always @(posedge clk or posedge reset) begin
        if (reset) m_lfsr <= 10'h2A5;
        else       m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(posedge clk); #1;
            frame_tick = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cubo"},   32'(cubo_verde), 32'd0);
        check({tag, "_pos_x"},  32'(pos_x),      32'd304);
        check({tag, "_pos_y"},  32'(pos_y),      32'd0);
        check({tag, "_caidas"}, 32'(caidas),     32'd0);
        check({tag, "_estado"}, 32'(estado),     32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        video_on   = 1'b0;
        pixel_x    = '0;
        pixel_y    = '0;
        frame_tick = 1'b0;
        pausa      = 1'b0;
        #12;
        check_reset_state("rst");
        @(posedge clk); #1;
        reset = 1'b0;

        // Horizontal scan across the cube at row 0, one clock of lag on the flag
        video_on = 1'b1;
        for (int px = 303; px <= 336; px++) begin
            pixel_x = 10'(px);
            @(posedge clk); #1;
            check("scan_x", 32'(cubo_verde), 32'(px >= 304 && px <= 335));
        end
        pixel_x = 10'd310; pixel_y = 10'd31;
        @(posedge clk); #1;
        check("row31_hit", 32'(cubo_verde), 32'd1);
        pixel_x = 10'd400;
        #1;
        check("lag_hold", 32'(cubo_verde), 32'd1);
        @(posedge clk); #1;
        check("lag_miss", 32'(cubo_verde), 32'd0);
        pixel_x = 10'd310; pixel_y = 10'd32;
        @(posedge clk); #1;
        check("row32_miss", 32'(cubo_verde), 32'd0);
        pixel_y = 10'd5; video_on = 1'b0;
        @(posedge clk); #1;
        check("blank_miss", 32'(cubo_verde), 32'd0);

        // Fall with a 10-tick pause in CAYENDO
        tick(1);
        check("t1_estado", 32'(estado), 32'd1);
        check("t1_pos_y",  32'(pos_y),  32'd0);
        tick(50);
        check("t51_pos_y", 32'(pos_y),  32'd100);
        pausa = 1'b1;
        tick(10);
        check("pause_fall_pos_y",  32'(pos_y),  32'd100);
        check("pause_fall_estado", 32'(estado), 32'd1);
        pausa = 1'b0;
        tick(173);
        check("pre_land_pos_y",  32'(pos_y),  32'd446);
        check("pre_land_estado", 32'(estado), 32'd1);
        tick(1);
        check("land_pos_y",  32'(pos_y),  32'd448);
        check("land_estado", 32'(estado), 32'd2);

        // Hold with a 10-tick pause in ATERRIZADO
        pausa = 1'b1;
        tick(10);
        check("pause_hold_pos_y",  32'(pos_y),  32'd448);
        check("pause_hold_estado", 32'(estado), 32'd2);
        pausa = 1'b0;
        tick(1);
        check("hold1_pos_y", 32'(pos_y), 32'd448);
        tick(28);
        check("hold29_estado", 32'(estado), 32'd2);
        check("hold29_caidas", 32'(caidas), 32'd0);

        // 30th hold tick; the tick stays high through REAPARECE and must be ignored
        frame_tick = 1'b1;
        @(posedge clk); #1;
        check("reap_estado", 32'(estado), 32'd3);
        check("reap_pos_y",  32'(pos_y),  32'd448);
`ifdef CUBO_LFSR_EN
        exp_x = m_lfsr & 10'h3E0;
        if (exp_x > 10'd608) exp_x = exp_x - 10'd512;
`else
        exp_x = 10'd304;
`endif
        @(posedge clk); #1;
        frame_tick = 1'b0;
        check("respawn_estado", 32'(estado), 32'd1);
        check("respawn_pos_y",  32'(pos_y),  32'd0);
        check("respawn_caidas", 32'(caidas), 32'd1);
        check("respawn_pos_x",  32'(pos_x),  32'(exp_x));
`ifdef CUBO_LFSR_EN
        check("respawn_x_align",  32'(pos_x % 32),     32'd0);
        check("respawn_x_bound",  32'(pos_x <= 10'd608), 32'd1);
`endif
        @(posedge clk); #1;
        check("post_reap_pos_y", 32'(pos_y), 32'd0);

        // Continuous ticks: each fall/hold/respawn cycle is 224 + 30 + 1 = 255 clocks
        frame_tick = 1'b1;
        for (int i = 1; i <= 255 * 255; i++) begin
            @(posedge clk); #1;
            if (i == 255 * 255 - 1) check("wrap_pre_caidas", 32'(caidas), 32'd255);
        end
        frame_tick = 1'b0;
        check("wrap_caidas", 32'(caidas), 32'd0);
        check("wrap_estado", 32'(estado), 32'd1);
        check("wrap_pos_y",  32'(pos_y),  32'd0);

        // Asynchronous reset mid-fall with the flag high
        tick(50);
        check("mid_pos_y", 32'(pos_y), 32'd100);
        video_on = 1'b1;
        pixel_x  = pos_x + 10'd5;
        pixel_y  = 10'd100;
        @(posedge clk); #1;
        check("mid_hit", 32'(cubo_verde), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async_rst");
        @(posedge clk); #1;
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_cubo_verde.md
# control_cubo_verde

Frame-rate controller for the falling green cube. It owns the cube's position and runs the fall/land/respawn sequence, advancing once per video frame. Each pixel clock it compares the scan position with the cube box and drives the registered `cubo_verde` hit flag. That flag feeds the RGB pixel multiplexer, which selects green for hit pixels and white for the background.

## Interface
- `CUBE_SIZE`, 32: cube edge in pixels; power of two.
- `H_RES`, 640: visible width; `H_RES - CUBE_SIZE` must be ≥ 511.
- `V_RES`, 480: visible height.
- `FALL_STEP`, 2: pixels moved per frame while falling.
- `HOLD_FRAMES`, 30: frames the cube rests on the floor; ≥ 1.
- `X_INIT`, 304: x position after reset.

- `clk` input 1: pixel clock.
- `reset` input 1: asynchronous, active-high.
- `video_on` input 1: visible-area flag from the sync generator.
- `pixel_x` input 10: current scan column.
- `pixel_y` input 10: current scan row.
- `frame_tick` input 1: one-cycle pulse per frame, issued during vertical blanking.
- `pausa` input 1: level; freezes the motion and hold counters.
- `cubo_verde` output 1: registered pixel-hit flag.
- `pos_x` output 10: cube left edge.
- `pos_y` output 10: cube top edge.
- `caidas` output 8: completed-respawn counter.
- `estado` output 2: encoded FSM state.

## Operation
- Floor: `FLOOR = V_RES - CUBE_SIZE` (448 at the defaults).
- States and encodings: ESPERA = 0, CAYENDO = 1, ATERRIZADO = 2, REAPARECE = 3.
- ESPERA: on `frame_tick` go to CAYENDO. The cube does not move on this tick.
- CAYENDO: on `frame_tick` with `pausa` = 0:
  - if `pos_y + FALL_STEP ≥ FLOOR`, set `pos_y` to FLOOR, clear the hold counter, and go to ATERRIZADO;
  - otherwise `pos_y += FALL_STEP`.
  - Compute the sum at 11 bits so it cannot overflow.
- ATERRIZADO: on `frame_tick` with `pausa` = 0, increment the hold counter. On the `HOLD_FRAMES`-th counted tick, go to REAPARECE.
- REAPARECE: lasts exactly one cycle and needs no tick. It sets:
  - `pos_y` to 0;
  - `pos_x` to the respawn x (see Configuration);
  - `caidas` to `caidas + 1`, wrapping from 255 to 0;
  - the next state to CAYENDO.
- `pausa` has no effect in ESPERA or REAPARECE.
- A `frame_tick` that falls in the REAPARECE cycle is ignored.
- LFSR: 10 bits, taps x^10 + x^7 + 1, seed 10'h2A5. It shifts every clock in all states and never reaches zero.
- `cubo_verde` is registered each clock as 1 when all of these hold:
  - `video_on` = 1;
  - `pos_x ≤ pixel_x < pos_x + CUBE_SIZE`;
  - `pos_y ≤ pixel_y < pos_y + CUBE_SIZE`.
- The box comparison uses the current `pos_x`/`pos_y` in every state, so the cube is also drawn in ESPERA.

## Timing
- Reset values:
  - `cubo_verde` = 0, `pos_x` = `X_INIT`, `pos_y` = 0, `caidas` = 0, `estado` = ESPERA;
  - hold counter = 0, LFSR = 10'h2A5.
- Reset takes effect immediately, including mid-fall or mid-hold, and the block returns to ESPERA.
- `cubo_verde` lags `pixel_x`/`pixel_y`/`video_on` by exactly one clock.
- Position outputs change one clock after the qualifying `frame_tick`, or at the end of the REAPARECE cycle.
- Fall duration at the defaults:
  - tick 1 exits ESPERA;
  - ticks 2 to 225 move the cube; tick 225 makes `pos_y` = 448 and `estado` = 2;
  - ticks 226 to 255 are the 30 hold ticks; tick 255 enters REAPARECE;
  - one clock later `pos_y` = 0, `caidas` = 1, `estado` = 1.

## Configuration
- `CUBO_LFSR_EN` defined: respawn x candidate is `lfsr & ~(CUBE_SIZE-1)`. If the candidate is greater than `H_RES - CUBE_SIZE`, use candidate − 512. The result is always aligned and on screen.
- `CUBO_LFSR_EN` undefined: respawn x is always `X_INIT` and the LFSR is removed.

## Test plan
- Reset, then scan `pixel_x` = 304..335 with `pixel_y` = 0 and `video_on` = 1 → `cubo_verde` = 1 one clock after each of those pixels and 0 at 303 and 336. `video_on` = 0 → `cubo_verde` = 0.
- 225 `frame_tick`s → `pos_y` = 448 and `estado` = 2; the next `frame_tick` leaves `pos_y` at 448.
- 30 further ticks → one-clock REAPARECE, then `pos_y` = 0 and `caidas` = 1. With `CUBO_LFSR_EN`, `pos_x` matches the LFSR model and is ≤ 608 and a multiple of 32; without it, `pos_x` = 304.
- `pausa` = 1 across 10 ticks in CAYENDO and again across 10 ticks in ATERRIZADO → position and hold count unchanged; landing and respawn each arrive 10 ticks late.
- Run 256 full cycles → `caidas` wraps 255 → 0.
- Assert `reset` asynchronously mid-fall at `pos_y` = 100 → all outputs return to their reset values with no clock edge required.
